// File: rtl/adbg_axi_slave_pkg.sv
// Shared types and AXI encodings for the adbg_axi_slave_mem responder.
package adbg_axi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WRESP,
        RDATA
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/adbg_axi_slave_mem_array.sv
// Flop-array storage with a byte-strobed write port and a combinational read port.
module adbg_axi_slave_mem_array #(
    parameter  int DATA_WIDTH = 64,
    parameter  int DEPTH      = 64,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage deliberately has no reset so contents survive a mid-transaction
    // reset; sequential state is always assigned with <= to avoid evaluation races.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adbg_axi_slave_mem.sv
// AXI4 slave responder over a small flop memory, one transaction at a time.
// Define ADBG_AXI_SLAVE_ERR_EN to enable SLVERR reporting for out-of-range/WRAP/oversize bursts.
module adbg_axi_slave_mem
    import adbg_axi_slave_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int MEM_DEPTH      = 64
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,

    input  logic                        axi_slave_aw_valid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr,
    input  logic [2:0]                  axi_slave_aw_prot,
    input  logic [3:0]                  axi_slave_aw_region,
    input  logic [7:0]                  axi_slave_aw_len,
    input  logic [2:0]                  axi_slave_aw_size,
    input  logic [1:0]                  axi_slave_aw_burst,
    input  logic                        axi_slave_aw_lock,
    input  logic [3:0]                  axi_slave_aw_cache,
    input  logic [3:0]                  axi_slave_aw_qos,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user,
    output logic                        axi_slave_aw_ready,

    input  logic                        axi_slave_ar_valid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr,
    input  logic [2:0]                  axi_slave_ar_prot,
    input  logic [3:0]                  axi_slave_ar_region,
    input  logic [7:0]                  axi_slave_ar_len,
    input  logic [2:0]                  axi_slave_ar_size,
    input  logic [1:0]                  axi_slave_ar_burst,
    input  logic                        axi_slave_ar_lock,
    input  logic [3:0]                  axi_slave_ar_cache,
    input  logic [3:0]                  axi_slave_ar_qos,
    input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_ar_user,
    output logic                        axi_slave_ar_ready,

    input  logic                        axi_slave_w_valid,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
    input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user,
    input  logic                        axi_slave_w_last,
    output logic                        axi_slave_w_ready,

    output logic                        axi_slave_r_valid,
    output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data,
    output logic [1:0]                  axi_slave_r_resp,
    output logic                        axi_slave_r_last,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_r_user,
    input  logic                        axi_slave_r_ready,

    output logic                        axi_slave_b_valid,
    output logic [1:0]                  axi_slave_b_resp,
    output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id,
    output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user,
    input  logic                        axi_slave_b_ready
);

    localparam int OFS    = $clog2(AXI_DATA_WIDTH / 8);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    state_t                    state_q, state_d;
    logic                      en_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [IDX_W-1:0]          idx_q, idx_next, raddr, aw_idx, ar_idx;
    logic [7:0]                len_q, cnt_q;
    logic [1:0]                burst_q;
    logic                      err_q, wlast_err_q;
    logic [1:0]                b_resp_q, r_resp_q;
    logic [AXI_DATA_WIDTH-1:0] r_data_q, rd_data;
    logic                      r_last_q;
    logic                      aw_hs, ar_hs, w_hs, mem_we;
    logic                      aw_err, ar_err, wlast_bad;
    logic                      unused_inputs;

    assign aw_idx = axi_slave_aw_addr[IDX_W+OFS-1:OFS];
    assign ar_idx = axi_slave_ar_addr[IDX_W+OFS-1:OFS];

`ifdef ADBG_AXI_SLAVE_ERR_EN
    // Out-of-range means the last beat's full word address reaches MEM_DEPTH; no aliasing.
    function automatic logic burst_err(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                       input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic [AXI_ADDR_WIDTH:0] span;
        logic [AXI_ADDR_WIDTH:0] last_word;
        span      = (burst == BURST_FIXED) ? '0 : (AXI_ADDR_WIDTH+1)'(len);
        last_word = (AXI_ADDR_WIDTH+1)'(addr >> OFS) + span;
        return (burst == BURST_WRAP) || (size > 3'(OFS)) ||
               (last_word >= (AXI_ADDR_WIDTH+1)'(MEM_DEPTH));
    endfunction

    assign aw_err    = burst_err(axi_slave_aw_addr, axi_slave_aw_len, axi_slave_aw_size, axi_slave_aw_burst);
    assign ar_err    = burst_err(axi_slave_ar_addr, axi_slave_ar_len, axi_slave_ar_size, axi_slave_ar_burst);
    assign wlast_bad = axi_slave_w_last != (cnt_q == len_q);
`else
    assign aw_err    = 1'b0;
    assign ar_err    = 1'b0;
    assign wlast_bad = 1'b0;
`endif

    assign unused_inputs = ^{axi_slave_aw_prot, axi_slave_aw_region, axi_slave_aw_lock,
                             axi_slave_aw_cache, axi_slave_aw_qos, axi_slave_aw_user,
                             axi_slave_aw_size, axi_slave_aw_addr,
                             axi_slave_ar_prot, axi_slave_ar_region, axi_slave_ar_lock,
                             axi_slave_ar_cache, axi_slave_ar_qos, axi_slave_ar_user,
                             axi_slave_ar_size, axi_slave_ar_addr,
                             axi_slave_w_user, axi_slave_w_last};

    // en_q keeps the ready outputs at 0 during reset and through the release cycle.
    assign axi_slave_aw_ready = en_q && (state_q == IDLE);
    assign axi_slave_ar_ready = en_q && (state_q == IDLE) && !axi_slave_aw_valid;
    assign axi_slave_w_ready  = (state_q == WDATA);
    assign axi_slave_b_valid  = (state_q == WRESP);
    assign axi_slave_r_valid  = (state_q == RDATA);

    assign aw_hs  = axi_slave_aw_valid && axi_slave_aw_ready;
    assign ar_hs  = axi_slave_ar_valid && axi_slave_ar_ready;
    assign w_hs   = (state_q == WDATA) && axi_slave_w_valid;
    assign mem_we = w_hs && !err_q;

    assign idx_next = (burst_q == BURST_FIXED) ? idx_q : idx_q + IDX_W'(1);
    assign raddr    = (state_q == IDLE) ? ar_idx : idx_next;

    adbg_axi_slave_mem_array #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_mem (
        .clk   (axi_aclk),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (axi_slave_w_data),
        .wstrb (axi_slave_w_strb[STRB_W-1:0]),
        .raddr (raddr),
        .rdata (rd_data)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // NOTE: next-state takes its default first so no path through the block infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (aw_hs) state_d = WDATA;
                     else if (ar_hs) state_d = RDATA;
            WDATA:   if (w_hs && (cnt_q == len_q)) state_d = WRESP;
            WRESP:   if (axi_slave_b_ready) state_d = IDLE;
            RDATA:   if (axi_slave_r_ready && r_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            en_q        <= 1'b0;
            id_q        <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            burst_q     <= BURST_FIXED;
            err_q       <= 1'b0;
            wlast_err_q <= 1'b0;
            b_resp_q    <= RESP_OKAY;
            r_resp_q    <= RESP_OKAY;
            r_data_q    <= '0;
            r_last_q    <= 1'b0;
        end else begin
            en_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        id_q        <= axi_slave_aw_id;
                        idx_q       <= aw_idx;
                        len_q       <= axi_slave_aw_len;
                        burst_q     <= axi_slave_aw_burst;
                        cnt_q       <= '0;
                        err_q       <= aw_err;
                        wlast_err_q <= 1'b0;
                    end else if (ar_hs) begin
                        id_q     <= axi_slave_ar_id;
                        idx_q    <= ar_idx;
                        len_q    <= axi_slave_ar_len;
                        burst_q  <= axi_slave_ar_burst;
                        cnt_q    <= '0;
                        err_q    <= ar_err;
                        r_data_q <= ar_err ? '0 : rd_data;
                        r_last_q <= (axi_slave_ar_len == 8'd0);
                        r_resp_q <= ar_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + 8'd1;
                        idx_q <= idx_next;
                        if (wlast_bad) wlast_err_q <= 1'b1;
                        if (cnt_q == len_q) begin
                            b_resp_q <= (err_q || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                RDATA: begin
                    if (axi_slave_r_ready) begin
                        if (r_last_q) begin
                            r_last_q <= 1'b0;
                        end else begin
                            cnt_q    <= cnt_q + 8'd1;
                            idx_q    <= idx_next;
                            r_data_q <= err_q ? '0 : rd_data;
                            r_last_q <= ((cnt_q + 8'd1) == len_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign axi_slave_r_data = r_data_q;
    assign axi_slave_r_resp = r_resp_q;
    assign axi_slave_r_last = r_last_q;
    assign axi_slave_r_id   = id_q;
    assign axi_slave_r_user = '0;
    assign axi_slave_b_resp = b_resp_q;
    assign axi_slave_b_id   = id_q;
    assign axi_slave_b_user = '0;

endmodule

// File: tb/tb_adbg_axi_slave_mem.sv
// Directed bench for adbg_axi_slave_mem with a read-data scoreboard; honours ADBG_AXI_SLAVE_ERR_EN.
module tb_adbg_axi_slave_mem;
    import adbg_axi_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        aw_valid, aw_lock, aw_ready;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot, aw_size, aw_id;
    logic [3:0]  aw_region, aw_cache, aw_qos;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic [5:0]  aw_user;

    logic        ar_valid, ar_lock, ar_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot, ar_size, ar_id;
    logic [3:0]  ar_region, ar_cache, ar_qos;
    logic [7:0]  ar_len;
    logic [1:0]  ar_burst;
    logic [5:0]  ar_user;

    logic        w_valid, w_last, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [5:0]  w_user;

    logic        r_valid, r_last, r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [2:0]  r_id;
    logic [5:0]  r_user;

    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;

    logic [27:0] out_vec;
    assign out_vec = {aw_ready, ar_ready, w_ready, r_valid, r_last, b_valid,
                      r_resp, b_resp, r_id, b_id, r_user, b_user};

    always #5 clk = ~clk;

    adbg_axi_slave_mem dut (
        .axi_aclk            (clk),
        .axi_aresetn         (rst_n),
        .axi_slave_aw_valid  (aw_valid),
        .axi_slave_aw_addr   (aw_addr),
        .axi_slave_aw_prot   (aw_prot),
        .axi_slave_aw_region (aw_region),
        .axi_slave_aw_len    (aw_len),
        .axi_slave_aw_size   (aw_size),
        .axi_slave_aw_burst  (aw_burst),
        .axi_slave_aw_lock   (aw_lock),
        .axi_slave_aw_cache  (aw_cache),
        .axi_slave_aw_qos    (aw_qos),
        .axi_slave_aw_id     (aw_id),
        .axi_slave_aw_user   (aw_user),
        .axi_slave_aw_ready  (aw_ready),
        .axi_slave_ar_valid  (ar_valid),
        .axi_slave_ar_addr   (ar_addr),
        .axi_slave_ar_prot   (ar_prot),
        .axi_slave_ar_region (ar_region),
        .axi_slave_ar_len    (ar_len),
        .axi_slave_ar_size   (ar_size),
        .axi_slave_ar_burst  (ar_burst),
        .axi_slave_ar_lock   (ar_lock),
        .axi_slave_ar_cache  (ar_cache),
        .axi_slave_ar_qos    (ar_qos),
        .axi_slave_ar_id     (ar_id),
        .axi_slave_ar_user   (ar_user),
        .axi_slave_ar_ready  (ar_ready),
        .axi_slave_w_valid   (w_valid),
        .axi_slave_w_data    (w_data),
        .axi_slave_w_strb    (w_strb),
        .axi_slave_w_user    (w_user),
        .axi_slave_w_last    (w_last),
        .axi_slave_w_ready   (w_ready),
        .axi_slave_r_valid   (r_valid),
        .axi_slave_r_data    (r_data),
        .axi_slave_r_resp    (r_resp),
        .axi_slave_r_last    (r_last),
        .axi_slave_r_id      (r_id),
        .axi_slave_r_user    (r_user),
        .axi_slave_r_ready   (r_ready),
        .axi_slave_b_valid   (b_valid),
        .axi_slave_b_resp    (b_resp),
        .axi_slave_b_id      (b_id),
        .axi_slave_b_user    (b_user),
        .axi_slave_b_ready   (b_ready)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [2:0]  id;
    } rexp_t;

    rexp_t       sb[$];
    logic [63:0] model_mem [64];
    logic [63:0] wbeats [256];
    int          tests;
    int          fails;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model word index: one full word per beat, FIXED stays put, modulo depth.
    function automatic int widx(input logic [31:0] addr, input int b, input logic [1:0] burst);
        return int'(((addr >> 3) + ((burst == BURST_FIXED) ? 0 : b)) % 64);
    endfunction

    // All tasks start and end at negedge+1.
    task automatic do_write(input logic [2:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [7:0] strb,
                            input logic [1:0] exp_resp, input bit upd);
        int n;
        aw_valid = 1'b1; aw_addr = addr; aw_len = len[7:0]; aw_burst = burst;
        aw_size = 3'd3; aw_id = id;
        n = 0;
        while (!aw_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("aw_accept", aw_ready, 1);
        @(posedge clk); @(negedge clk); #1;
        aw_valid = 1'b0;
        check("w_ready_after_aw", w_ready, 1);
        for (int b = 0; b <= len; b++) begin
            w_valid = 1'b1; w_data = wbeats[b]; w_strb = strb; w_last = (b == len);
            n = 0;
            while (!w_ready && n < 20) begin @(negedge clk); #1; n++; end
            check("w_ready_beat", w_ready, 1);
            if (upd) begin
                for (int k = 0; k < 8; k++)
                    if (strb[k]) model_mem[widx(addr, b, burst)][k*8 +: 8] = wbeats[b][k*8 +: 8];
            end
            @(posedge clk); @(negedge clk); #1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        check("b_valid_after_last", b_valid, 1);
        check("b_id", b_id, id);
        check("b_resp", b_resp, exp_resp);
        b_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        b_ready = 1'b0;
        check("b_valid_dropped", b_valid, 0);
    endtask

    task automatic do_read(input logic [2:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input bit err, input bit stall,
                           output int cycles);
        int          n, got, cyc;
        bit          stalled;
        logic [63:0] held_data;
        logic        held_last;
        rexp_t       e;
        for (int b = 0; b <= len; b++) begin
            e.data = err ? 64'h0 : model_mem[widx(addr, b, burst)];
            e.last = (b == len);
            e.resp = err ? RESP_SLVERR : RESP_OKAY;
            e.id   = id;
            sb.push_back(e);
        end
        ar_valid = 1'b1; ar_addr = addr; ar_len = len[7:0]; ar_burst = burst;
        ar_size = 3'd3; ar_id = id;
        n = 0;
        while (!ar_ready && n < 20) begin @(negedge clk); #1; n++; end
        check("ar_accept", ar_ready, 1);
        @(posedge clk); @(negedge clk); #1;
        ar_valid = 1'b0;
        check("r_valid_after_ar", r_valid, 1);
        got = 0; cyc = 0; stalled = 0; held_data = '0; held_last = 1'b0;
        while (got <= len && cyc < 2000) begin
            r_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (stalled) begin
                check("r_data_stable", r_data, held_data);
                check("r_last_stable", r_last, held_last);
            end
            if (r_valid && r_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("r_data", r_data, e.data);
                check("r_last", r_last, e.last);
                check("r_resp", r_resp, e.resp);
                check("r_id", r_id, e.id);
                got++;
                stalled = 0;
            end else if (r_valid) begin
                stalled = 1;
                held_data = r_data;
                held_last = r_last;
            end
            @(posedge clk); @(negedge clk); #1;
            cyc++;
        end
        r_ready = 1'b0;
        check("r_beat_count", got, len + 1);
        check("r_valid_dropped", r_valid, 0);
        cycles = cyc;
    endtask

    initial begin
        int cycles;
        tests = 0; fails = 0;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        aw_valid = 0; aw_addr = 0; aw_prot = 0; aw_region = 0; aw_len = 0; aw_size = 0;
        aw_burst = 0; aw_lock = 0; aw_cache = 0; aw_qos = 0; aw_id = 0; aw_user = 0;
        ar_valid = 0; ar_addr = 0; ar_prot = 0; ar_region = 0; ar_len = 0; ar_size = 0;
        ar_burst = 0; ar_lock = 0; ar_cache = 0; ar_qos = 0; ar_id = 0; ar_user = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_user = 0; w_last = 0;
        r_ready = 0; b_ready = 0;
        rst_n = 1'b0;

        #1;
        check("reset_outputs", 64'(out_vec), 0);
        check("reset_r_data", r_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("aw_ready_before_first_clk", aw_ready, 0);
        @(posedge clk); @(negedge clk); #1;
        check("aw_ready_after_release", aw_ready, 1);

        // Single write then read back.
        wbeats[0] = 64'hDEADBEEF_CAFEF00D;
        do_write(3'd3, 32'h10, 0, BURST_INCR, 8'hFF, RESP_OKAY, 1);
        do_read(3'd5, 32'h10, 0, BURST_INCR, 0, 0, cycles);

        // Strobe merge: expected word 0 = FFFFFFFF_00000000.
        wbeats[0] = '1;
        do_write(3'd1, 32'h0, 0, BURST_INCR, 8'hFF, RESP_OKAY, 1);
        wbeats[0] = '0;
        do_write(3'd1, 32'h0, 0, BURST_INCR, 8'h0F, RESP_OKAY, 1);
        do_read(3'd2, 32'h0, 0, BURST_INCR, 0, 0, cycles);

        // 16-beat INCR burst, data = beat number.
        for (int b = 0; b < 16; b++) wbeats[b] = 64'(b);
        do_write(3'd6, 32'h0, 15, BURST_INCR, 8'hFF, RESP_OKAY, 1);
        do_read(3'd7, 32'h0, 15, BURST_INCR, 0, 0, cycles);
        check("incr_read_cycles", cycles, 16);

        // Backpressure on a 4-beat read.
        do_read(3'd4, 32'h0, 3, BURST_INCR, 0, 1, cycles);

        // FIXED burst: all beats land on one word.
        wbeats[0] = 64'hA; wbeats[1] = 64'hB; wbeats[2] = 64'hC;
        do_write(3'd2, 32'h40, 2, BURST_FIXED, 8'hFF, RESP_OKAY, 1);
        do_read(3'd3, 32'h40, 2, BURST_FIXED, 0, 0, cycles);

        // Simultaneous AW/AR, then reset in WDATA.
        aw_valid = 1'b1; aw_addr = 32'h80; aw_len = 8'd3; aw_burst = BURST_INCR; aw_size = 3'd3; aw_id = 3'd1;
        ar_valid = 1'b1; ar_addr = 32'h10; ar_len = 8'd0; ar_burst = BURST_INCR; ar_size = 3'd3; ar_id = 3'd2;
        #1;
        check("arb_aw_ready", aw_ready, 1);
        check("arb_ar_ready", ar_ready, 0);
        @(posedge clk); @(negedge clk); #1;
        aw_valid = 1'b0; ar_valid = 1'b0;
        check("arb_in_wdata", w_ready, 1);
        w_valid = 1'b1; w_data = 64'h5555; w_strb = 8'hFF;
        model_mem[16] = 64'h5555;
        @(posedge clk); @(negedge clk); #1;
        w_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 64'(out_vec), 0);
        check("midreset_r_data", r_data, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset_aw_ready_held", aw_ready, 0);
        @(posedge clk); @(negedge clk); #1;
        check("midreset_aw_ready_back", aw_ready, 1);

        // Memory survives reset.
        do_read(3'd0, 32'h10, 0, BURST_INCR, 0, 0, cycles);

        // Write at word MEM_DEPTH, then a WRAP read.
        wbeats[0] = 64'h1234;
`ifdef ADBG_AXI_SLAVE_ERR_EN
        do_write(3'd5, 32'h200, 0, BURST_INCR, 8'hFF, RESP_SLVERR, 0);
        do_read(3'd1, 32'h0, 0, BURST_INCR, 0, 0, cycles);
        do_read(3'd4, 32'h0, 3, BURST_WRAP, 1, 0, cycles);
`else
        do_write(3'd5, 32'h200, 0, BURST_INCR, 8'hFF, RESP_OKAY, 1);
        do_read(3'd1, 32'h0, 0, BURST_INCR, 0, 0, cycles);
        do_read(3'd4, 32'h0, 3, BURST_WRAP, 0, 0, cycles);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
